// File: rtl/serial_add_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding and default geometry.
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_SIZE  = 4;
   localparam int DEF_WORDS = 4;

endpackage

// File: rtl/add_slice.sv
// Combinational SIZE-bit adder slice with carry in/out, time-shared by the controller.
module add_slice #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            ci,
   output logic [SIZE-1:0] s,
   output logic            co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds two W-bit operands by stepping one SIZE-bit slice over WORDS cycles, LSB slice first.
//
// state   | meaning
// ST_IDLE | waiting for start; result registers hold last value
// ST_RUN  | one slice per cycle, carry registered between slices
// ST_DONE | result valid for one cycle; start here chains the next op
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int SIZE  = DEF_SIZE,
   parameter int WORDS = DEF_WORDS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SIZE*WORDS-1:0] a,
   input  logic [SIZE*WORDS-1:0] b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [SIZE*WORDS-1:0] sum,
   output logic                  carry,
   output logic                  overflow
);

   localparam int W  = SIZE * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_t          state;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic            c_r;
   logic [IW-1:0]   idx;
   logic [SIZE-1:0] sl_a;
   logic [SIZE-1:0] sl_b;
   logic [SIZE-1:0] sl_s;
   logic            sl_co;

   assign sl_a = a_r[idx*SIZE +: SIZE];
   assign sl_b = b_r[idx*SIZE +: SIZE];

   add_slice #(.SIZE(SIZE)) u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (c_r),
      .s  (sl_s),
      .co (sl_co)
   );

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a_r      <= '0;
         b_r      <= '0;
         c_r      <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_r      <= a;
                  b_r      <= b;
                  c_r      <= cin;
                  idx      <= '0;
                  sum      <= '0;
                  carry    <= 1'b0;
                  overflow <= 1'b0;
                  state    <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum[idx*SIZE +: SIZE] <= sl_s;
               c_r                   <= sl_co;
               if (idx == LAST) begin
                  // sl_s here is the top slice, so its MSB is the result sign bit
                  idx      <= '0;
                  carry    <= sl_co;
                  overflow <= (a_r[W-1] == b_r[W-1]) && (sl_s[SIZE-1] != a_r[W-1]);
                  state    <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (SIZE=4, WORDS=4) with hand-computed expectations.
module tb_serial_add_ctrl;

   localparam int SIZE  = 4;
   localparam int WORDS = 4;
   localparam int W     = SIZE * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.SIZE(SIZE), .WORDS(WORDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive operands with start high across one edge, then drop start
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      a     = av;
      b     = bv;
      cin   = cv;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = '1;
      b     = '1;
      cin   = 1'b1;
   endtask

   // walk the WORDS run cycles, then check the done cycle and result
   task automatic finish_op(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
      for (int i = 0; i < WORDS; i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         tick();
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_lo"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_carry"}, 32'(carry), 32'(ec));
      check({tag, "_ovf"}, 32'(overflow), 32'(eo));
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // 1: small add
      start_op(16'h0002, 16'h000B, 1'b0);
      finish_op("t1", 16'h000D, 1'b0, 1'b0);
      tick();
      check("t1_idle_done", 32'(done), 32'd0);
      check("t1_hold_sum", 32'(sum), 32'h000D);
      tick();
      check("t1_idle_busy", 32'(busy), 32'd0);

      // 2: full ripple; sum cleared at accepting edge
      start_op(16'hFFFF, 16'h0001, 1'b0);
      check("t2_clr_sum", 32'(sum), 32'd0);
      finish_op("t2", 16'h0000, 1'b1, 1'b0);
      tick();

      // 3: signed overflow both directions
      start_op(16'h7FFF, 16'h0001, 1'b0);
      finish_op("t3a", 16'h8000, 1'b0, 1'b1);
      tick();
      start_op(16'h8000, 16'h8000, 1'b0);
      finish_op("t3b", 16'h0000, 1'b1, 1'b1);
      tick();
      check("t3_hold_carry", 32'(carry), 32'd1);
      check("t3_hold_ovf", 32'(overflow), 32'd1);

      // 4: back-to-back via start held in ST_DONE
      start_op(16'h0F0F, 16'h00F1, 1'b1);
      for (int i = 0; i < WORDS; i++) begin
         check("t4a_busy", 32'(busy), 32'd1);
         tick();
      end
      check("t4a_done", 32'(done), 32'd1);
      check("t4a_sum", 32'(sum), 32'h1001);
      check("t4a_carry", 32'(carry), 32'd0);
      check("t4a_ovf", 32'(overflow), 32'd0);
      a     = 16'h0001;
      b     = 16'h0001;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4b_accept_busy", 32'(busy), 32'd1);
      check("t4b_accept_clr", 32'(sum), 32'd0);
      finish_op("t4b", 16'h0002, 1'b0, 1'b0);
      tick();

      // 5: start during ST_RUN ignored
      start_op(16'h0006, 16'h0003, 1'b0);
      start = 1'b1;
      a     = 16'h1111;
      b     = 16'h1111;
      finish_op("t5", 16'h0009, 1'b0, 1'b0);
      start = 1'b0;
      tick();
      check("t5_single_done", 32'(done), 32'd0);
      check("t5_idle_busy", 32'(busy), 32'd0);
      tick();
      check("t5_still_idle", 32'(done), 32'd0);

      // 6: reset mid-operation, then a clean op
      start_op(16'h1234, 16'h1111, 1'b0);
      tick();
      tick();
      check("t6_mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      check("t6_rst_sum", 32'(sum), 32'd0);
      check("t6_rst_carry", 32'(carry), 32'd0);
      check("t6_rst_ovf", 32'(overflow), 32'd0);
      tick();
      check("t6_idle_busy", 32'(busy), 32'd0);
      start_op(16'h1234, 16'h1111, 1'b0);
      finish_op("t6", 16'h2345, 1'b0, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
